// File: rtl/trunc_err_monitor.sv
// trunc_err_monitor
// Streaming error-statistics stage for a truncated adder. Each accepted
// sample (a, b, approx_sum) is compared with the exact sum. Over a window of
// WIN samples the absolute error is summed, the peak error is tracked and the
// inexact results are counted. The record is then offered on a valid/ready
// handshake.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             opens a window (honoured only in IDLE)
//   in_valid/in_ready sample handshake (a, b, approx_sum)
//   out_valid/out_ready result handshake (err_sum, err_max, miss_cnt)
//   busy              high whenever the FSM is not IDLE
//   sat_flag          only with TRUNC_ERR_SAT_EN: err_sum has saturated
//
// Configuration macro: TRUNC_ERR_SAT_EN
//   defined   -> err_sum saturates at 2^ACC_W-1 and sat_flag is present
//   undefined -> err_sum wraps modulo 2^ACC_W and sat_flag is absent
module trunc_err_monitor #(
  parameter int N     = 8,
  parameter int T     = 4,
  parameter int WIN   = 16,
  parameter int ACC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic [N-1:0]             approx_sum,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         err_sum,
  output logic [N:0]               err_max,
  output logic [$clog2(WIN+1)-1:0] miss_cnt,
`ifdef TRUNC_ERR_SAT_EN
  output logic                     sat_flag,
`endif
  output logic                     busy
);

  localparam int CNT_W = $clog2(WIN+1);

  // T only documents the upstream adder; it must still describe a legal adder.
  if (T > N) begin : g_bad_t
    $error("trunc_err_monitor: T must not exceed N");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] sample_cnt;
  logic             drain_cnt;
  logic             accept;
  logic             last_accept;
  logic             open_window;

  // Stage 1 holds the raw sample, stage 2 holds its absolute error.
  logic             s1_valid;
  logic [N-1:0]     s1_a;
  logic [N-1:0]     s1_b;
  logic [N-1:0]     s1_approx;
  logic             s2_valid;
  logic [N:0]       s2_err;
  logic [N:0]       exact;
  logic [N:0]       approx_ext;
  logic [N:0]       err_now;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (sample_cnt == CNT_W'(WIN - 1));
  assign open_window = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; DRAIN lasts two cycles so the two pipeline stages empty
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start)       next_state = ACCUM;
      ACCUM:   if (last_accept) next_state = DRAIN;
      DRAIN:   if (drain_cnt)   next_state = REPORT;
      REPORT:  if (out_ready)   next_state = IDLE;
      default:                  next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == REPORT);
    busy      = (state != IDLE);
  end

  // Sample counter and drain timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
      drain_cnt  <= 1'b0;
    end else begin
      if (open_window)  sample_cnt <= '0;
      else if (accept)  sample_cnt <= sample_cnt + 1'b1;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Absolute error at N+1 bits, so a lost carry shows up as err >= 2^N
  always_comb begin
    exact      = {1'b0, s1_a} + {1'b0, s1_b};
    approx_ext = {1'b0, s1_approx};
    err_now    = (exact >= approx_ext) ? (exact - approx_ext) : (approx_ext - exact);
  end

  // Two-stage pipeline: capture sample, then register its error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_approx <= '0;
      s2_valid  <= 1'b0;
      s2_err    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a      <= a;
        s1_b      <= b;
        s1_approx <= approx_sum;
      end
      s2_valid <= s1_valid;
      s2_err   <= s1_valid ? err_now : '0;
    end
  end

`ifdef TRUNC_ERR_SAT_EN
  // Wide enough to hold err_sum plus one full error without overflow
  localparam int SUM_W = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = (SUM_W'(1) << ACC_W) - SUM_W'(1);
  logic [SUM_W-1:0] sum_wide;
  assign sum_wide = SUM_W'(err_sum) + SUM_W'(s2_err);
`endif

  // Accumulators: cleared when a window opens, updated by each stage-2 error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum  <= '0;
      err_max  <= '0;
      miss_cnt <= '0;
`ifdef TRUNC_ERR_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else if (open_window) begin
      err_sum  <= '0;
      err_max  <= '0;
      miss_cnt <= '0;
`ifdef TRUNC_ERR_SAT_EN
      sat_flag <= 1'b0;
`endif
    end else if (s2_valid) begin
`ifdef TRUNC_ERR_SAT_EN
      if (sum_wide > ACC_MAX) begin
        err_sum  <= ACC_MAX[ACC_W-1:0];
        sat_flag <= 1'b1;
      end else begin
        err_sum  <= sum_wide[ACC_W-1:0];
      end
`else
      err_sum <= err_sum + ACC_W'(s2_err);
`endif
      if (s2_err > err_max) err_max  <= s2_err;
      if (s2_err != '0)     miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_trunc_err_monitor.sv
// Bench for trunc_err_monitor with N=8, WIN=4, ACC_W=8. The narrow
// accumulator makes wrap/saturation behaviour show up in ordinary windows.
module tb_trunc_err_monitor;

  localparam int N     = 8;
  localparam int WIN   = 4;
  localparam int ACC_W = 8;
`ifdef TRUNC_ERR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] approx_sum;
  logic         out_valid;
  logic         out_ready;
  logic [ACC_W-1:0] err_sum;
  logic [N:0]   err_max;
  logic [2:0]   miss_cnt;
  logic         busy;
`ifdef TRUNC_ERR_SAT_EN
  logic         sat_flag;
`endif

  trunc_err_monitor #(.N(N), .T(4), .WIN(WIN), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .approx_sum(approx_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_sum(err_sum), .err_max(err_max), .miss_cnt(miss_cnt),
`ifdef TRUNC_ERR_SAT_EN
    .sat_flag(sat_flag),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    a[4];
    int    b[4];
    int    p[4];
    int    exp_sum;
    int    exp_max;
    int    exp_miss;
    bit    exp_sat;
  } vec_t;

  vec_t vecs[4];
  int   cur_a[4];
  int   cur_b[4];
  int   cur_p[4];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    wait_edge();
    start = 1'b0;
  endtask

  // Offers one sample and waits (bounded) until the DUT accepts it
  task automatic send_sample(input int ai, input int bi, input int pi);
    bit took = 1'b0;
    int guard = 0;
    a = ai[7:0]; b = bi[7:0]; approx_sum = pi[7:0];
    in_valid = 1'b1;
    while (!took && guard < 50) begin
      took = in_ready;
      wait_edge();
      guard++;
    end
    if (!took) checkOutput("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Opens a window and feeds cur_* with optional random idle gaps
  task automatic applyStimulus(input bit gaps);
    pulse_start();
    for (int i = 0; i < WIN; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 2)) wait_edge();
      end
      send_sample(cur_a[i], cur_b[i], cur_p[i]);
    end
  endtask

  task automatic check_results(input string tag, input int s, input int m, input int c, input bit sat);
    checkOutput({tag, "_err_sum"},  32'(err_sum),  32'(s));
    checkOutput({tag, "_err_max"},  32'(err_max),  32'(m));
    checkOutput({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(c));
`ifdef TRUNC_ERR_SAT_EN
    checkOutput({tag, "_sat_flag"}, 32'(sat_flag), 32'(sat));
`else
    if (sat) checkOutput({tag, "_sat_unexpected"}, 32'd0, 32'd1);
`endif
  endtask

  // Called just after the last acceptance: checks the two drain cycles,
  // the record, a held REPORT phase (with an ignored start) and the release
  task automatic finish_window(input string tag, input int s, input int m, input int c,
                               input bit sat, input int hold);
    checkOutput({tag, "_ov_drain0"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy_drain"}, 32'(busy), 32'd1);
    wait_edge();
    checkOutput({tag, "_ov_drain1"}, 32'(out_valid), 32'd0);
    wait_edge();
    checkOutput({tag, "_ov_report"}, 32'(out_valid), 32'd1);
    check_results(tag, s, m, c, sat);
    for (int k = 0; k < hold; k++) begin
      start = (k == 1);
      wait_edge();
      start = 1'b0;
      checkOutput({tag, "_ov_hold"}, 32'(out_valid), 32'd1);
      checkOutput({tag, "_sum_hold"}, 32'(err_sum), 32'(s));
    end
    out_ready = 1'b1;
    wait_edge();
    out_ready = 1'b0;
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
    checkOutput({tag, "_ov_idle"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_max_idle"}, 32'(err_max), 32'(m));
  endtask

  // Reference model: plain integer arithmetic over the whole window
  task automatic model(output int s, output int m, output int c, output bit sat);
    int total = 0;
    m = 0; c = 0;
    for (int i = 0; i < WIN; i++) begin
      int e = cur_a[i] + cur_b[i] - cur_p[i];
      if (e < 0) e = -e;
      total += e;
      if (e > m) m = e;
      if (e != 0) c++;
    end
    if (SAT) begin
      sat = (total > 255);
      s = sat ? 255 : total;
    end else begin
      sat = 1'b0;
      s = total % 256;
    end
  endtask

  task automatic load_vec(input int k);
    for (int i = 0; i < WIN; i++) begin
      cur_a[i] = vecs[k].a[i]; cur_b[i] = vecs[k].b[i]; cur_p[i] = vecs[k].p[i];
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int es, em, ec;
    bit esat;

    vecs[0].name = "exact";
    vecs[0].a = '{'h20, 'h20, 'h20, 'h20};
    vecs[0].b = '{'h30, 'h30, 'h30, 'h30};
    vecs[0].p = '{'h50, 'h50, 'h50, 'h50};
    vecs[0].exp_sum = 0;   vecs[0].exp_max = 0;   vecs[0].exp_miss = 0; vecs[0].exp_sat = 0;

    // errors 16, 8, 256, 0 -> total 280
    vecs[1].name = "mixed";
    vecs[1].a = '{'h0F, 'h23, 'hF0, 'h01};
    vecs[1].b = '{'h01, 'h45, 'h10, 'h01};
    vecs[1].p = '{'h00, 'h60, 'h00, 'h02};
    vecs[1].exp_sum = SAT ? 255 : 24; vecs[1].exp_max = 256; vecs[1].exp_miss = 3; vecs[1].exp_sat = SAT;

    // each error 510-240 = 270 -> total 1080
    vecs[2].name = "satur";
    vecs[2].a = '{'hFF, 'hFF, 'hFF, 'hFF};
    vecs[2].b = '{'hFF, 'hFF, 'hFF, 'hFF};
    vecs[2].p = '{'hF0, 'hF0, 'hF0, 'hF0};
    vecs[2].exp_sum = SAT ? 255 : 56; vecs[2].exp_max = 270; vecs[2].exp_miss = 4; vecs[2].exp_sat = SAT;

    // approx above exact and lost carry: errors 16, 255, 256, 1 -> total 528
    vecs[3].name = "above";
    vecs[3].a = '{'h10, 'h00, 'h80, 'h7F};
    vecs[3].b = '{'h10, 'h00, 'h80, 'h00};
    vecs[3].p = '{'h30, 'hFF, 'h00, 'h7E};
    vecs[3].exp_sum = SAT ? 255 : 16; vecs[3].exp_max = 256; vecs[3].exp_miss = 4; vecs[3].exp_sat = SAT;

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; approx_sum = '0;
    wait_edge();
    wait_edge();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    check_results("rst", 0, 0, 0, 1'b0);
    rst = 1'b0;
    wait_edge();

    // start-to-ready latency
    start = 1'b1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd0);
    wait_edge();
    start = 1'b0;
    checkOutput("accum_in_ready", 32'(in_ready), 32'd1);
    load_vec(0);
    for (int i = 0; i < WIN; i++) send_sample(cur_a[i], cur_b[i], cur_p[i]);
    finish_window("first", 0, 0, 0, 1'b0, 0);

    // table-driven windows
    for (int k = 0; k < 4; k++) begin
      load_vec(k);
      applyStimulus(1'b0);
      finish_window(vecs[k].name, vecs[k].exp_sum, vecs[k].exp_max,
                    vecs[k].exp_miss, vecs[k].exp_sat, 0);
    end

    // in_valid pattern 1,0,1,1,0,1 then REPORT held for 5 cycles
    load_vec(1);
    pulse_start();
    begin
      int pat[6] = '{1, 0, 1, 1, 0, 1};
      int idx = 0;
      for (int i = 0; i < 6; i++) begin
        in_valid = pat[i][0];
        if (pat[i] == 1) begin
          a = cur_a[idx][7:0]; b = cur_b[idx][7:0]; approx_sum = cur_p[idx][7:0];
          idx++;
        end
        wait_edge();
      end
      in_valid = 1'b0;
    end
    finish_window("gaps", vecs[1].exp_sum, vecs[1].exp_max, vecs[1].exp_miss, vecs[1].exp_sat, 5);

    // start pulsed in the middle of ACCUM must not restart the count
    load_vec(3);
    pulse_start();
    send_sample(cur_a[0], cur_b[0], cur_p[0]);
    send_sample(cur_a[1], cur_b[1], cur_p[1]);
    pulse_start();
    send_sample(cur_a[2], cur_b[2], cur_p[2]);
    send_sample(cur_a[3], cur_b[3], cur_p[3]);
    finish_window("start_accum", vecs[3].exp_sum, vecs[3].exp_max, vecs[3].exp_miss, vecs[3].exp_sat, 0);

    // asynchronous reset after two acceptances, with errors already summed
    load_vec(1);
    pulse_start();
    send_sample(cur_a[0], cur_b[0], cur_p[0]);
    send_sample(cur_a[1], cur_b[1], cur_p[1]);
    wait_edge();
    wait_edge();
    checkOutput("pre_rst_sum", 32'(err_sum), 32'd24);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_results("mid_rst", 0, 0, 0, 1'b0);
    wait_edge();
    rst = 1'b0;
    wait_edge();
    load_vec(3);
    applyStimulus(1'b0);
    finish_window("after_rst", vecs[3].exp_sum, vecs[3].exp_max, vecs[3].exp_miss, vecs[3].exp_sat, 0);

    // randomized windows against the model
    for (int w = 0; w < 12; w++) begin
      for (int i = 0; i < WIN; i++) begin
        cur_a[i] = $urandom_range(0, 255);
        cur_b[i] = $urandom_range(0, 255);
        case ($urandom_range(0, 2))
          0:       cur_p[i] = (cur_a[i] + cur_b[i]) % 256;
          1:       cur_p[i] = ((cur_a[i] & 'hF0) + (cur_b[i] & 'hF0)) % 256;
          default: cur_p[i] = $urandom_range(0, 255);
        endcase
      end
      model(es, em, ec, esat);
      applyStimulus(1'b1);
      finish_window($sformatf("rand%0d", w), es, em, ec, esat, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
